// File: rtl/bit_pack_fifo_if.sv
// ----------------------------------------------------------------------------
// bit_pack_fifo_if
// Purpose : groups the serial-write / byte-read signals of bit_pack_fifo.
// Signals : bit_in     - serial data bit
//           wr         - write strobe, pushes bit_in
//           rd         - read strobe, pops one complete byte
//           flush      - commit a partial byte, zero-padded (optional feature)
//           data_out   - last popped byte, registered
//           empty      - no complete byte stored
//           full       - DEPTH complete bytes stored
//           data_count - bits held (8 x stored bytes + pending bits)
//           overflow   - sticky, a write was dropped
// Modports: master drives the strobes (producer/consumer side),
//           slave is the FIFO itself.
// ----------------------------------------------------------------------------
interface bit_pack_fifo_if;
    logic        bit_in;
    logic        wr;
    logic        rd;
    logic        flush;
    logic [7:0]  data_out;
    logic        empty;
    logic        full;
    logic [31:0] data_count;
    logic        overflow;

    modport master (
        output bit_in, wr, rd, flush,
        input  data_out, empty, full, data_count, overflow
    );

    modport slave (
        input  bit_in, wr, rd, flush,
        output data_out, empty, full, data_count, overflow
    );
endinterface

// File: rtl/bit_pack_fifo.sv
// ----------------------------------------------------------------------------
// bit_pack_fifo
// Purpose : packs a serial bit stream MSB-first into bytes and queues the
//           completed bytes in a DEPTH-entry byte buffer.
// Ports   : clk   - sole clock, rising edge
//           rst_n - asynchronous active-low reset
//           bus   - bit_pack_fifo_if.slave (see interface header)
// Params  : DEPTH - byte-buffer depth, power of two, >= 2
// Macro   : BIT_PACK_FIFO_FLUSH_EN - when defined, flush commits a partial
//           byte left-aligned and zero-padded; otherwise flush is ignored.
// ----------------------------------------------------------------------------
module bit_pack_fifo #(
    parameter int DEPTH = 4
) (
    input logic             clk,
    input logic             rst_n,
    bit_pack_fifo_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);

    // Pointers carry one extra bit so full and empty are distinguishable.
    logic [PW:0]  r_wptr;
    logic [PW:0]  r_rptr;
    logic [2:0]   r_bit_idx;
    logic [7:0]   r_asm;
    logic [31:0]  r_count;
    logic         r_ovf;
    logic [7:0]   r_dout;
    logic [7:0]   r_mem [DEPTH];

    logic         w_full;
    logic         w_empty;
    logic         w_wr_acc;
    logic         w_rd_acc;
    logic         w_byte_done;
    logic         w_flush_do;
    logic         w_commit;
    logic [2:0]   w_idx_wr;
    logic [7:0]   w_asm_wr;
    logic [3:0]   w_pad;
    logic [31:0]  w_count_next;

    assign w_empty  = (r_wptr == r_rptr);
    assign w_full   = ((r_wptr - r_rptr) == (PW+1)'(DEPTH));
    assign w_wr_acc = bus.wr && !w_full;
    assign w_rd_acc = bus.rd && !w_empty;

    // NOTE: every signal assigned in an always_comb gets a default first so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_asm_wr = r_asm;
        // Bits are placed directly at position 7-idx (~idx for 3 bits), so a
        // partial byte is already left-aligned and zero-padded.
        if (w_wr_acc) begin
            w_asm_wr[~r_bit_idx] = bus.bit_in;
        end
    end

    assign w_byte_done = w_wr_acc && (r_bit_idx == 3'd7);
    // Wraps to 0 when the eighth bit is taken.
    assign w_idx_wr    = r_bit_idx + 3'(w_wr_acc);

`ifdef BIT_PACK_FIFO_FLUSH_EN
    // The write bit is packed first; a flush only acts on what is then left.
    assign w_flush_do = bus.flush && !w_full && !w_byte_done && (w_idx_wr != 3'd0);
    assign w_pad      = w_flush_do ? (4'd8 - {1'b0, w_idx_wr}) : 4'd0;
`else
    logic w_unused_flush;
    assign w_unused_flush = bus.flush;
    assign w_flush_do     = 1'b0;
    assign w_pad          = 4'd0;
`endif

    assign w_commit     = w_byte_done || w_flush_do;
    // +1 per accepted bit, -8 per accepted read, + padding when flushing.
    assign w_count_next = r_count + 32'(w_wr_acc) - (w_rd_acc ? 32'd8 : 32'd0)
                        + 32'(w_pad);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_bit_idx <= '0;
            r_asm     <= '0;
            r_count   <= '0;
            r_ovf     <= 1'b0;
            r_dout    <= '0;
        end else begin
            if (w_commit) begin
                r_wptr    <= r_wptr + 1'b1;
                r_bit_idx <= '0;
                r_asm     <= '0;
            end else if (w_wr_acc) begin
                r_bit_idx <= w_idx_wr;
                r_asm     <= w_asm_wr;
            end

            if (bus.wr && w_full) begin
                r_ovf <= 1'b1;
            end

            if (w_rd_acc) begin
                r_dout <= r_mem[r_rptr[PW-1:0]];
                r_rptr <= r_rptr + 1'b1;
            end

            r_count <= w_count_next;
        end
    end

    // NOTE: the byte buffer has no reset; the pointers alone define which
    // entries are valid, so stale contents are never observable.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            r_mem[r_wptr[PW-1:0]] <= w_asm_wr;
        end
    end

    assign bus.data_out   = r_dout;
    assign bus.empty      = w_empty;
    assign bus.full       = w_full;
    assign bus.data_count = r_count;
    assign bus.overflow   = r_ovf;
endmodule

// File: tb/tb_bit_pack_fifo.sv
// ----------------------------------------------------------------------------
// tb_bit_pack_fifo
// Self-checking bench for bit_pack_fifo. A queue-based reference model tracks
// stored bytes and pending bits; a negedge process compares every output each
// cycle, and literal expectations pin the model at key points.
// ----------------------------------------------------------------------------
module tb_bit_pack_fifo;
    localparam int DEPTH = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    bit_pack_fifo_if bus ();

    bit_pack_fifo #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    logic [7:0] m_q[$];
    bit         m_bits[$];
    logic [7:0] m_dout;
    logic       m_ovf;
    logic [7:0] rd_log[$];
    bit         cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] pack_bits();
        logic [7:0] v = 8'h00;
        foreach (m_bits[i]) v[7-i] = m_bits[i];
        return v;
    endfunction

    function automatic logic [31:0] m_count();
        return 32'(8 * m_q.size() + m_bits.size());
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_bits.delete();
        m_dout = 8'h00;
        m_ovf  = 1'b0;
    endtask

    // One clock edge of the model, using the state seen before the edge.
    task automatic model_edge(input bit w, input bit r, input bit b, input bit f);
        bit full0  = (m_q.size() == DEPTH);
        bit empty0 = (m_q.size() == 0);
        if (w) begin
            if (full0) m_ovf = 1'b1;
            else begin
                m_bits.push_back(b);
                if (m_bits.size() == 8) begin
                    m_q.push_back(pack_bits());
                    m_bits.delete();
                end
            end
        end
`ifdef BIT_PACK_FIFO_FLUSH_EN
        if (f && !full0 && m_bits.size() != 0) begin
            m_q.push_back(pack_bits());
            m_bits.delete();
        end
`else
        if (f) begin end
`endif
        if (r && !empty0) begin
            m_dout = m_q.pop_front();
            rd_log.push_back(m_dout);
        end
    endtask

    task automatic step(input bit w, input bit r, input bit b, input bit f);
        bus.wr     = w;
        bus.rd     = r;
        bus.bit_in = b;
        bus.flush  = f;
        @(posedge clk);
        model_edge(w, r, b, f);
        #1;
    endtask

    task automatic idle_inputs();
        bus.wr     = 1'b0;
        bus.rd     = 1'b0;
        bus.bit_in = 1'b0;
        bus.flush  = 1'b0;
    endtask

    // Asserts reset mid-cycle and checks the outputs clear immediately.
    task automatic async_reset();
        idle_inputs();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_data_out",   32'(bus.data_out), 32'h00);
        check("rst_empty",      32'(bus.empty), 32'd1);
        check("rst_full",       32'(bus.full), 32'd0);
        check("rst_data_count", bus.data_count, 32'd0);
        check("rst_overflow",   32'(bus.overflow), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic write_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) step(1'b1, 1'b0, v[i], 1'b0);
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_en && rst_n) begin
            check("cyc_data_out",   32'(bus.data_out), 32'(m_dout));
            check("cyc_empty",      32'(bus.empty), 32'(m_q.size() == 0));
            check("cyc_full",       32'(bus.full), 32'(m_q.size() == DEPTH));
            check("cyc_data_count", bus.data_count, m_count());
            check("cyc_overflow",   32'(bus.overflow), 32'(m_ovf));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pat;
        logic [7:0] sent [40];
        int         bitpos;
        int         cyc;
        bit         w;
        bit         r;
        bit         b;

        idle_inputs();
        model_reset();
        #3;
        check("init_empty",      32'(bus.empty), 32'd1);
        check("init_data_count", bus.data_count, 32'd0);
        #9 rst_n = 1'b1;
        cmp_en = 1'b1;

        // Bits 1,0,1,1,0,0,1,0 pack to 8'hB2.
        pat = 8'hB2;
        write_byte(pat);
        check("b2_empty", 32'(bus.empty), 32'd0);
        check("b2_count", bus.data_count, 32'd8);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("b2_data_out", 32'(bus.data_out), 32'hB2);
        check("b2_count_after", bus.data_count, 32'd0);
        // Read while empty is ignored and data_out holds.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("empty_rd_hold", 32'(bus.data_out), 32'hB2);

        // Fill to full, then a write with a read in the same cycle is dropped.
        for (int i = 0; i < 32; i++) step(1'b1, 1'b0, 1'($urandom_range(1)), 1'b0);
        check("fill_full",  32'(bus.full), 32'd1);
        check("fill_count", bus.data_count, 32'd32);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        check("ovf_flag",  32'(bus.overflow), 32'd1);
        check("ovf_count", bus.data_count, 32'd24);
        check("ovf_full",  32'(bus.full), 32'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        check("drain_empty", 32'(bus.empty), 32'd1);
        check("ovf_sticky",  32'(bus.overflow), 32'd1);
        async_reset();

        // One byte stored plus 3 pending, then simultaneous write and read.
        write_byte(8'hA5);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        check("rw_count_pre", bus.data_count, 32'd11);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        check("rw_count_post", bus.data_count, 32'd4);
        check("rw_data_out",   32'(bus.data_out), 32'hA5);
        async_reset();

        // Flush of bits 1,1,0.
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
`ifdef BIT_PACK_FIFO_FLUSH_EN
        check("flush_count", bus.data_count, 32'd8);
        check("flush_empty", 32'(bus.empty), 32'd0);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        check("flush_data_out", 32'(bus.data_out), 32'hC0);
        check("flush_idx0_noop", bus.data_count, 32'd0);
`else
        check("noflush_count", bus.data_count, 32'd3);
        check("noflush_empty", 32'(bus.empty), 32'd1);
`endif
        async_reset();

        // Reset mid-byte discards the partial data.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 1'b0);
        async_reset();
        write_byte(8'hFF);
        check("post_rst_count", bus.data_count, 32'd8);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("post_rst_data", 32'(bus.data_out), 32'hFF);
        async_reset();

        // Stream 40 random bytes with random gaps through pointer wrap.
        rd_log.delete();
        foreach (sent[i]) sent[i] = 8'($urandom);
        bitpos = 0;
        cyc    = 0;
        while (rd_log.size() < 40 && cyc < 6000) begin
            w = (bitpos < 320) && (m_q.size() < DEPTH) && ($urandom_range(3) != 0);
            r = ($urandom_range(2) == 0);
            b = w ? sent[bitpos / 8][7 - (bitpos % 8)] : 1'b0;
            step(w, r, b, 1'b0);
            if (w) bitpos++;
            cyc++;
        end
        check("stream_done", 32'(rd_log.size()), 32'd40);
        for (int i = 0; i < 40 && i < rd_log.size(); i++)
            check($sformatf("stream_byte%0d", i), 32'(rd_log[i]), 32'(sent[i]));
        check("stream_overflow", 32'(bus.overflow), 32'd0);

        // Unconstrained random traffic including flush and full drops.
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(1)), ($urandom_range(3) == 0),
                 1'($urandom_range(1)), ($urandom_range(5) == 0));

        idle_inputs();
        @(posedge clk);
        model_edge(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
